mmio_slot_bridge: RTL and testbench
===================================

MMIO_SLOT_BRIDGE -- requirements
Module: mmio_slot_bridge

Interface
REQ-001 Parameter NUM_SLOTS, default 8, number of MMIO slave slots (power of two, 2..64).
REQ-002 Parameter SLOT_ADDR_W, default 5, word-address bits per slot.
REQ-003 Parameter TIMEOUT, default 255, max wait cycles for slot_ready (1..65535).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 io_addr_strobe, io_read_strobe, io_write_strobe  in  1 each  MCS I/O bus request strobes.
REQ-007 io_byte_enable  in  4, io_address  in  32, io_write_data  in  32  MCS request fields.
REQ-008 io_read_data  out  32, io_ready  out  1  MCS response.
REQ-009 slot_cs  out  NUM_SLOTS  one-hot slot select; slot_read, slot_write  out  1 each  access direction.
REQ-010 slot_addr  out  SLOT_ADDR_W, slot_byte_enable  out  4, slot_write_data  out  32  registered access fields.
REQ-011 slot_read_data  in  NUM_SLOTS*32  flattened per-slot read data, slot i at [32*i +: 32].
REQ-012 slot_ready  in  NUM_SLOTS  per-slot access-complete.
REQ-013 err_timeout, err_decode  out  1 each  sticky error flags; err_clear  in  1  clears both.

Function
REQ-014 Decode: slot index = io_address[2+SLOT_ADDR_W +: log2(NUM_SLOTS)], register = io_address[2 +: SLOT_ADDR_W]; request is in range iff io_address[31:24] = 8'hC0 and all bits above the index field below bit 24 are zero.
REQ-015 FSM states IDLE, ACCESS, RESP; one request outstanding at a time.
REQ-016 IDLE: on io_addr_strobe with read or write strobe, latch address, byte enable, write data, direction; go ACCESS if in range, else RESP with err_decode set.
REQ-017 Both read and write strobes asserted together: access is a write.
REQ-018 ACCESS: slot_cs[index] high, slot_read/slot_write per direction, fields stable, held until slot_ready[index] sampled high.
REQ-019 ACCESS with slot_ready[index] high: capture slot_read_data[index] (reads), go RESP; slot_ready of non-selected slots ignored.
REQ-020 ACCESS cycle counter starts at 0; when it reaches TIMEOUT without ready, go RESP, set err_timeout, return 32'hDEAD_BEEF.
REQ-021 RESP: io_ready high exactly one cycle, io_read_data valid that cycle (0 for writes and decode errors); next state IDLE.
REQ-022 Minimum latency: strobe cycle N, slot_cs cycle N+1, ready same cycle -> io_ready cycle N+2.
REQ-023 io_addr_strobe outside IDLE is ignored; no queuing.
REQ-024 err_clear wins over a simultaneous set; flags otherwise sticky until cleared.
REQ-025 slot_cs, slot_read, slot_write low in IDLE and RESP.

Reset
REQ-026 Reset forces IDLE, counter 0, all outputs 0, both error flags 0, including mid-ACCESS (in-flight access abandoned, no io_ready).

Structure
REQ-027 Package mmio_bridge_pkg holds state enum, IO_BASE (8'hC0), TIMEOUT_DATA (32'hDEAD_BEEF).
REQ-028 Sub-module mmio_timeout_counter: clear/enable inputs, TIMEOUT parameter, expired output.

Verification
REQ-029 Write 0xC000_0084 data 0x1234_5678, slot 1 ready immediately -> slot_cs=0x02, slot_addr=1, io_ready at N+2, no errors.
REQ-030 Read slot 3 reg 0, ready after 5 wait cycles, data 0xA5A5_0001 -> io_read_data=0xA5A5_0001 with io_ready at N+7.
REQ-031 Read slot 2 never ready, TIMEOUT=16 -> io_ready after 16 ACCESS cycles, data 0xDEAD_BEEF, err_timeout=1; err_clear -> 0.
REQ-032 Read 0x8000_0000 -> no slot_cs, io_ready at N+1, data 0, err_decode=1.
REQ-033 Reset asserted mid-ACCESS -> outputs 0 immediately, no io_ready; next request completes normally.
REQ-034 Strobe during ACCESS and read+write strobes together -> second request ignored; combined request issues slot_write only.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the MCS I/O bus to MMIO slot bridge.
// Holds the FSM state encoding, address window base and timeout read value.
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [7:0]  IO_BASE      = 8'hC0;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int          CNT_W        = 16;

    // Mask of address bits [23:low_w] that must be zero for an in-range access.
    function automatic logic [31:0] upper_zero_mask(input int low_w);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 24; b++) begin
            if (b >= low_w) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mmio_timeout_counter.sv
// Wait-cycle counter for an outstanding slot access.
// Counts enabled cycles from zero and flags expiry on the TIMEOUT-th one.
module mmio_timeout_counter
    import mmio_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q >= LIMIT);

    // Next count: clear wins, then advance while enabled and not yet expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_slot_bridge.sv
// Bridges single MCS I/O bus requests onto one of NUM_SLOTS MMIO slots.
// One request in flight; decode and timeout errors are reported as sticky flags.
module mmio_slot_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_ADDR_W = 5,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_addr_strobe,
    input  logic                    io_read_strobe,
    input  logic                    io_write_strobe,
    input  logic [3:0]              io_byte_enable,
    input  logic [31:0]             io_address,
    input  logic [31:0]             io_write_data,
    output logic [31:0]             io_read_data,
    output logic                    io_ready,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    slot_read,
    output logic                    slot_write,
    output logic [SLOT_ADDR_W-1:0]  slot_addr,
    output logic [3:0]              slot_byte_enable,
    output logic [31:0]             slot_write_data,
    input  logic [NUM_SLOTS*32-1:0] slot_read_data,
    input  logic [NUM_SLOTS-1:0]    slot_ready,
    output logic                    err_timeout,
    output logic                    err_decode,
    input  logic                    err_clear
);

    localparam int          IDX_W   = $clog2(NUM_SLOTS);
    localparam int          IDX_LSB = 2 + SLOT_ADDR_W;
    localparam logic [31:0] HI_MASK = upper_zero_mask(IDX_LSB + IDX_W);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SLOT_ADDR_W-1:0] reg_q, reg_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_to_q, err_to_d;
    logic                   err_dec_q, err_dec_d;

    logic                   req;
    logic                   in_range;
    logic                   set_to;
    logic                   set_dec;
    logic                   expired;
    logic                   in_access;
    logic                   rdy_sel;
    logic [31:0]            rdata_sel;
    logic [NUM_SLOTS-1:0]   sel_oh;

    assign req       = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign in_range  = (io_address[31:24] == IO_BASE)
                     && ((io_address & HI_MASK) == 32'h0);
    assign in_access = (state_q == ST_ACCESS);

    // Wait-cycle budget for the current access; idle outside ACCESS.
    mmio_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (!in_access),
        .enable_i  (in_access),
        .expired_o (expired)
    );

    // Pick the selected slot's ready and read data; other slots are ignored.
    always_comb begin
        sel_oh    = '0;
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_oh[i] = 1'b1;
                rdy_sel   = slot_ready[i];
                rdata_sel = slot_read_data[32*i +: 32];
            end
        end
    end

    // Next-state and datapath capture for the request FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        set_to  = 1'b0;
        set_dec = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = io_address[IDX_LSB +: IDX_W];
                    reg_d   = io_address[2 +: SLOT_ADDR_W];
                    be_d    = io_byte_enable;
                    wdata_d = io_write_data;
                    we_d    = io_write_strobe;
                    rdata_d = '0;
                    if (in_range) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_RESP;
                        set_dec = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (rdy_sel) begin
                    rdata_d = we_q ? 32'h0 : rdata_sel;
                    state_d = ST_RESP;
                end else if (expired) begin
                    rdata_d = TIMEOUT_DATA;
                    state_d = ST_RESP;
                    set_to  = 1'b1;
                end
            end
            ST_RESP: begin
                rdata_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_to_d  = err_clear ? 1'b0 : (err_to_q | set_to);
        err_dec_d = err_clear ? 1'b0 : (err_dec_q | set_dec);
    end

    // State, latched request fields, response data and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            reg_q     <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            err_to_q  <= 1'b0;
            err_dec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            reg_q     <= reg_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            err_to_q  <= err_to_d;
            err_dec_q <= err_dec_d;
        end
    end

    assign io_ready         = (state_q == ST_RESP);
    assign io_read_data     = io_ready ? rdata_q : 32'h0;
    assign slot_cs          = in_access ? sel_oh : '0;
    assign slot_read        = in_access & ~we_q;
    assign slot_write       = in_access & we_q;
    assign slot_addr        = reg_q;
    assign slot_byte_enable = be_q;
    assign slot_write_data  = wdata_q;
    assign err_timeout      = err_to_q;
    assign err_decode       = err_dec_q;

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// Directed bench for mmio_slot_bridge with a response scoreboard.
// Stimulus queues expected io_ready data/cycle; a monitor pops on io_ready.
module tb_mmio_slot_bridge;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic         clk;
    logic         reset;
    logic         io_addr_strobe;
    logic         io_read_strobe;
    logic         io_write_strobe;
    logic [3:0]   io_byte_enable;
    logic [31:0]  io_address;
    logic [31:0]  io_write_data;
    logic [31:0]  io_read_data;
    logic         io_ready;
    logic [7:0]   slot_cs;
    logic         slot_read;
    logic         slot_write;
    logic [4:0]   slot_addr;
    logic [3:0]   slot_byte_enable;
    logic [31:0]  slot_write_data;
    logic [255:0] slot_read_data;
    logic [7:0]   slot_ready;
    logic         err_timeout;
    logic         err_decode;
    logic         err_clear;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    rsp_t q[$];

    int         wait_cfg [8];
    logic [7:0] noise    = 8'h00;
    int         wcnt     = 0;
    bit         prev_cs  = 1'b0;

    mmio_slot_bridge #(
        .NUM_SLOTS   (8),
        .SLOT_ADDR_W (5),
        .TIMEOUT     (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_addr_strobe   (io_addr_strobe),
        .io_read_strobe   (io_read_strobe),
        .io_write_strobe  (io_write_strobe),
        .io_byte_enable   (io_byte_enable),
        .io_address       (io_address),
        .io_write_data    (io_write_data),
        .io_read_data     (io_read_data),
        .io_ready         (io_ready),
        .slot_cs          (slot_cs),
        .slot_read        (slot_read),
        .slot_write       (slot_write),
        .slot_addr        (slot_addr),
        .slot_byte_enable (slot_byte_enable),
        .slot_write_data  (slot_write_data),
        .slot_read_data   (slot_read_data),
        .slot_ready       (slot_ready),
        .err_timeout      (err_timeout),
        .err_decode       (err_decode),
        .err_clear        (err_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slot model: selected slot raises ready after wait_cfg cycles (-1 never).
    always @(posedge clk) begin
        logic [7:0] rdy;
        #1;
        if (slot_cs != 8'h00) begin
            if (!prev_cs) wcnt = 0;
            else wcnt++;
        end
        prev_cs = (slot_cs != 8'h00);
        rdy = noise;
        for (int i = 0; i < 8; i++) begin
            if (slot_cs[i]) rdy[i] = (wait_cfg[i] >= 0) && (wcnt >= wait_cfg[i]);
        end
        slot_ready = rdy;
    end

    // Monitor: every io_ready must match the oldest expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (!reset && io_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_io_ready", 32'(io_ready), 32'h0);
            end else begin
                r = q.pop_front();
                chk("rsp_data", io_read_data, r.data);
                chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic rd,
                         input logic wr, input logic clr,
                         input bit expect_rsp, input logic [31:0] exp_d,
                         input int lat);
        rsp_t r;
        @(posedge clk); #1;
        io_address      = a;
        io_write_data   = d;
        io_byte_enable  = be;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_addr_strobe  = 1'b1;
        err_clear       = clr;
        if (expect_rsp) begin
            r.data = exp_d;
            r.cyc  = cyc + lat;
            q.push_back(r);
        end
        @(posedge clk); #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        err_clear       = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'h0;
        io_address      = 32'h0;
        io_write_data   = 32'h0;
        err_clear       = 1'b0;
        slot_ready      = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_cfg[i] = 0;
            slot_read_data[32*i +: 32] = 32'h5A00_0000 + 32'(i);
        end
        slot_read_data[96 +: 32] = 32'hA5A5_0001;

        repeat (3) @(posedge clk); #1;
        chk("rst_cs", 32'(slot_cs), 32'h0);
        chk("rst_ready", 32'(io_ready), 32'h0);
        chk("rst_rdata", io_read_data, 32'h0);
        chk("rst_errs", 32'({err_timeout, err_decode}), 32'h0);
        chk("rst_addr", 32'(slot_addr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write slot 1 reg 1, ready immediately.
        wait_cfg[1] = 0;
        issue(32'hC000_0084, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0,
              1'b1, 32'h0, 2);
        @(negedge clk);
        chk("w1_cs", 32'(slot_cs), 32'h02);
        chk("w1_write", 32'(slot_write), 32'h1);
        chk("w1_read", 32'(slot_read), 32'h0);
        chk("w1_addr", 32'(slot_addr), 32'h1);
        chk("w1_wdata", slot_write_data, 32'h1234_5678);
        chk("w1_be", 32'(slot_byte_enable), 32'hF);
        wait_idle();
        chk("w1_errs", 32'({err_timeout, err_decode}), 32'h0);

        // Read slot 3 reg 0, five wait cycles.
        wait_cfg[3] = 5;
        issue(32'hC000_0180, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0,
              1'b1, 32'hA5A5_0001, 7);
        @(negedge clk);
        chk("r3_cs", 32'(slot_cs), 32'h08);
        chk("r3_read", 32'(slot_read), 32'h1);
        chk("r3_write", 32'(slot_write), 32'h0);
        wait_idle();

        // Read slot 2 never ready; other slots assert ready and are ignored.
        wait_cfg[2] = -1;
        noise = 8'hFB;
        issue(32'hC000_0114, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0,
              1'b1, 32'hDEAD_BEEF, 17);
        @(negedge clk);
        chk("to_cs", 32'(slot_cs), 32'h04);
        chk("to_addr", 32'(slot_addr), 32'h5);
        chk("to_be", 32'(slot_byte_enable), 32'h3);
        wait_idle();
        noise = 8'h00;
        chk("to_err_timeout", 32'(err_timeout), 32'h1);
        chk("to_err_decode", 32'(err_decode), 32'h0);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("to_cleared", 32'(err_timeout), 32'h0);

        // Out-of-window read: immediate response, decode error.
        issue(32'h8000_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0,
              1'b1, 32'h0, 1);
        @(negedge clk);
        chk("dec_cs", 32'(slot_cs), 32'h0);
        chk("dec_read", 32'(slot_read), 32'h0);
        wait_idle();
        chk("dec_err", 32'(err_decode), 32'h1);
        chk("dec_err_to", 32'(err_timeout), 32'h0);

        // Bit 10 set is out of range; clear in the same cycle wins.
        issue(32'hC000_0400, 32'h1, 4'hF, 1'b0, 1'b1, 1'b1,
              1'b1, 32'h0, 1);
        wait_idle();
        chk("clear_wins", 32'(err_decode), 32'h0);

        // Wrong top byte.
        issue(32'hC100_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0,
              1'b1, 32'h0, 1);
        wait_idle();
        chk("dec_top_err", 32'(err_decode), 32'h1);

        // Reset in the middle of an access.
        wait_cfg[4] = -1;
        issue(32'hC000_0200, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0,
              1'b0, 32'h0, 0);
        @(negedge clk);
        chk("mid_cs", 32'(slot_cs), 32'h10);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(slot_cs), 32'h0);
        chk("mid_rst_rw", 32'({slot_read, slot_write}), 32'h0);
        chk("mid_rst_ready", 32'(io_ready), 32'h0);
        chk("mid_rst_errs", 32'({err_timeout, err_decode}), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        wait_cfg[4] = 2;
        issue(32'hC000_0208, 32'hCAFE_0004, 4'hC, 1'b0, 1'b1, 1'b0,
              1'b1, 32'h0, 4);
        @(negedge clk);
        chk("post_cs", 32'(slot_cs), 32'h10);
        chk("post_addr", 32'(slot_addr), 32'h2);
        chk("post_write", 32'(slot_write), 32'h1);
        wait_idle();

        // Combined read+write strobe is a write; strobe during ACCESS ignored.
        wait_cfg[5] = 3;
        issue(32'hC000_0280, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, 1'b0,
              1'b1, 32'h0, 5);
        @(negedge clk);
        chk("rw_write", 32'(slot_write), 32'h1);
        chk("rw_read", 32'(slot_read), 32'h0);
        chk("rw_cs", 32'(slot_cs), 32'h20);
        @(posedge clk); #1;
        io_address      = 32'hC000_0300;
        io_write_data   = 32'h0;
        io_read_strobe  = 1'b1;
        io_addr_strobe  = 1'b1;
        @(posedge clk); #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        @(negedge clk);
        chk("ign_cs", 32'(slot_cs), 32'h20);
        chk("ign_addr", 32'(slot_addr), 32'h0);
        chk("ign_wdata", slot_write_data, 32'h0BAD_F00D);
        wait_idle();
        repeat (5) @(posedge clk);
        chk("sb_empty", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
